ecall_halt_control: RTL and testbench
=====================================

# ecall_halt_control

Decides, for an `ecall` sitting in ID, whether the pipeline must stall for `x17`, whether the call is a halt request, and how the pipeline drains before the CPU reports halted. Sits in the ID stage directly downstream of the ecall forwarding logic and consumes its forwarded `rs1` value, which carries `x17` for `ecall`. Drives the PC/IF-ID hold and flush controls and the top-level `is_halted`.

## Interface
- `HALT_CODE`, default 10: `x17` value that requests a halt.
- `DRAIN_CYCLES`, default 3: drain cycles after detection, covering the ecall's own EX, MEM and WB stages.
- `clk` in 1: core clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `is_ecall` in 1: ID-stage instruction is `ecall`.
- `ID_EX_rd` in 5: destination of the instruction in EX.
- `ID_EX_reg_write` in 1: the EX instruction writes a register.
- `EX_MEM_rd` in 5: destination of the instruction in MEM.
- `EX_MEM_reg_write` in 1: the MEM instruction writes a register.
- `EX_MEM_mem_read` in 1: the MEM instruction is a load.
- `rs1_dout_forwarded` in 32: `x17` value as resolved by ecall forwarding.
- `mem_stall` in 1: cache or memory freeze; the whole pipeline holds.
- `ecall_stall` out 1: hold PC and IF/ID, and insert a bubble into ID/EX.
- `halt_flush` out 1: squash IF/ID (wrong-path fetch behind a halting ecall).
- `halt_pending` out 1: FSM is in DRAIN.
- `is_halted` out 1: sticky halted flag.
- `ecall_stall_cycles` out 32: count of stall cycles; present only with `ECALL_STALL_CNT_EN`.

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset enters RUN and clears every output to 0, including the counter.
- **x17 hazard, RUN only:**
  - `hazard = is_ecall && ((ID_EX_reg_write && ID_EX_rd==17) || (EX_MEM_reg_write && EX_MEM_mem_read && EX_MEM_rd==17))`.
  - The forwarding path supplies only `EX_MEM_alu_out`. A producer still in EX, or a load in MEM, must therefore advance before the value is usable.
  - The register file is write-first, so a producer in WB is visible through the normal read.
  - While `hazard` is 1: `ecall_stall`=1 and `halt_flush`=0.
- **Halt detect:** in RUN, with `is_ecall && !hazard && !mem_stall && rs1_dout_forwarded==HALT_CODE`:
  - assert `halt_flush`=1 for that cycle;
  - load the drain counter with `DRAIN_CYCLES`;
  - next state is DRAIN.
- **Non-halt ecall:** `x17 != HALT_CODE` is a no-op, and the state stays RUN.
- **DRAIN:**
  - `ecall_stall`=1 and `halt_flush`=1 every cycle; `halt_pending`=1.
  - The counter decrements only on cycles with `mem_stall`=0.
  - When the counter reaches 0 on a non-stalled cycle, the next state is HALTED.
- **HALTED:**
  - `is_halted`=1, `ecall_stall`=1 and `halt_flush`=1, held until `reset_n` is low.
  - `is_ecall` and all hazard inputs are ignored.
- **mem_stall:**
  - In RUN, `ecall_stall` still reflects `hazard`, but no halt is detected.
  - The FSM and drain counter freeze.
- **Simultaneous events:** a hazard and a matching `HALT_CODE` in the same cycle resolves as a stall, not a halt. The halt is re-evaluated on the next cycle.
- **Reset mid-operation:** reset in DRAIN or HALTED returns to RUN immediately and asynchronously, with outputs 0.

## Timing
- `ecall_stall` and `halt_flush` are combinational from the inputs and the current state in RUN.
- In DRAIN and HALTED, all outputs are decoded purely from the state.
- With a halting ecall in ID at cycle T and no memory stalls:
  - DRAIN covers T+1 .. T+DRAIN_CYCLES;
  - `is_halted` first goes high at T+DRAIN_CYCLES+1 (T+4 by default).
  - Each `mem_stall` cycle during DRAIN delays this by one cycle.
- Hazard stall length:
  - 1 cycle for an ALU producer in EX;
  - 2 cycles for a load producer in EX;
  - 1 cycle for a load already in MEM.
- `ecall_stall_cycles` increments on every cycle where `ecall_stall`=1 in RUN. It saturates at `32'hFFFF_FFFF`.

## Configuration
- Macro: `ECALL_STALL_CNT_EN`.
- **Defined:** the `ecall_stall_cycles` port and its 32-bit saturating register exist, reset to 0.
- **Undefined:** both the port and the register are absent; all other behaviour is identical.

## Structure
- Shared package `ecall_pkg` holds:
  - `REG_X17` = 5'd17;
  - `HALT_CODE_DEFAULT` = 32'd10;
  - the `ecall_state_t` enum {RUN, DRAIN, HALTED}.
- One sub-module, `halt_drain_counter`:
  - loadable down-counter with enable (`!mem_stall`);
  - `zero` output;
  - asynchronous active-low clear.
- The FSM and hazard decode stay in the top module.

## Test plan
- **ALU hazard:** `addi x17,x0,10` in EX, `ecall` in ID → `ecall_stall`=1 for 1 cycle, then halt detected; `is_halted`=1 exactly 4 cycles after detection.
- **Load hazard:** `lw x17` in EX, `ecall` in ID → 2 stall cycles, then halt detection with forwarded value 10.
- **Non-halt ecall:** `x17`=93 → no stall, no flush, state stays RUN, `is_halted` stays 0.
- **Memory stall during drain:** `mem_stall`=1 for 5 cycles during DRAIN → `is_halted` delayed to detection+9.
- **Reset in drain:** `reset_n` low during DRAIN → all outputs 0 asynchronously; a fresh halting ecall after release halts normally.
- **Stall counter:** `ECALL_STALL_CNT_EN` defined, ALU-hazard scenario followed by halt → `ecall_stall_cycles` = 1.

Source files
------------

// File: rtl/ecall_pkg.sv
// Shared constants and the FSM state type for the ecall halt controller.
package ecall_pkg;

  localparam logic [4:0]  REG_X17           = 5'd17;
  localparam logic [31:0] HALT_CODE_DEFAULT = 32'd10;
  localparam int unsigned DRAIN_CNT_W       = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ecall_state_t;

endpackage

// File: rtl/ecall_halt_control_if.sv
// ID-stage signals consumed and produced by the ecall halt controller.
interface ecall_halt_control_if;
  logic        is_ecall;
  logic [4:0]  ID_EX_rd;
  logic        ID_EX_reg_write;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_reg_write;
  logic        EX_MEM_mem_read;
  logic [31:0] rs1_dout_forwarded;
  logic        mem_stall;
  logic        ecall_stall;
  logic        halt_flush;
  logic        halt_pending;
  logic        is_halted;

  modport master (
    output is_ecall, ID_EX_rd, ID_EX_reg_write, EX_MEM_rd, EX_MEM_reg_write,
           EX_MEM_mem_read, rs1_dout_forwarded, mem_stall,
    input  ecall_stall, halt_flush, halt_pending, is_halted
  );

  modport slave (
    input  is_ecall, ID_EX_rd, ID_EX_reg_write, EX_MEM_rd, EX_MEM_reg_write,
           EX_MEM_mem_read, rs1_dout_forwarded, mem_stall,
    output ecall_stall, halt_flush, halt_pending, is_halted
  );
endinterface

// File: rtl/ecall_halt_control_drain_counter.sv
// Loadable down-counter timing the pipeline drain; freezes while en is low.
module halt_drain_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ecall_halt_control.sv
// ecall x17 hazard stall, halt detection and drain sequencing for the ID stage.
// Optional stall-cycle counter port enabled by defining ECALL_STALL_CNT_EN.
module ecall_halt_control
  import ecall_pkg::*;
#(
  parameter logic [31:0] HALT_CODE    = HALT_CODE_DEFAULT,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ecall_halt_control_if.slave  bus
`ifdef ECALL_STALL_CNT_EN
  ,
  output logic [31:0]          ecall_stall_cycles
`endif
);

  ecall_state_t state_q, state_d;
  logic hazard;
  logic detect;
  logic cnt_zero;
  logic stall_d, flush_d, pending_d, halted_d;

  // Only EX_MEM ALU results are forwarded: a producer in EX or a load in MEM must advance.
  assign hazard = bus.is_ecall &&
                  ((bus.ID_EX_reg_write && (bus.ID_EX_rd == REG_X17)) ||
                   (bus.EX_MEM_reg_write && bus.EX_MEM_mem_read && (bus.EX_MEM_rd == REG_X17)));

  assign detect = (state_q == RUN) && bus.is_ecall && !hazard && !bus.mem_stall &&
                  (bus.rs1_dout_forwarded == HALT_CODE);

  // Loaded with DRAIN_CYCLES-1 so the last drain cycle is the one that sees zero.
  halt_drain_counter #(
    .WIDTH (DRAIN_CNT_W)
  ) u_drain_cnt (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (detect),
    .load_val (DRAIN_CNT_W'(DRAIN_CYCLES - 1)),
    .en       ((state_q == DRAIN) && !bus.mem_stall),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    pending_d = 1'b0;
    halted_d  = 1'b0;
    case (state_q)
      RUN: begin
        stall_d = hazard;
        flush_d = detect;
        if (detect) state_d = DRAIN;
      end
      DRAIN: begin
        stall_d   = 1'b1;
        flush_d   = 1'b1;
        pending_d = 1'b1;
        if (!bus.mem_stall && cnt_zero) state_d = HALTED;
      end
      HALTED: begin
        stall_d  = 1'b1;
        flush_d  = 1'b1;
        halted_d = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.ecall_stall  = stall_d;
  assign bus.halt_flush   = flush_d;
  assign bus.halt_pending = pending_d;
  assign bus.is_halted    = halted_d;

`ifdef ECALL_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if ((state_q == RUN) && hazard && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign ecall_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ecall_halt_control.sv
// Directed bench for ecall_halt_control; expectations queued per cycle and checked at negedge.
module tb_ecall_halt_control;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] exp;   // {ecall_stall, halt_flush, halt_pending, is_halted}
  } sb_t;
  sb_t sb[$];

  ecall_halt_control_if bus ();

`ifdef ECALL_STALL_CNT_EN
  logic [31:0] ecall_stall_cycles;
`endif

  ecall_halt_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef ECALL_STALL_CNT_EN
    ,
    .ecall_stall_cycles (ecall_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic ec, input logic id_we, input logic [4:0] id_rd,
                       input logic ex_we, input logic ex_mr, input logic [4:0] ex_rd,
                       input logic [31:0] x17, input logic ms);
    bus.is_ecall           = ec;
    bus.ID_EX_reg_write    = id_we;
    bus.ID_EX_rd           = id_rd;
    bus.EX_MEM_reg_write   = ex_we;
    bus.EX_MEM_mem_read    = ex_mr;
    bus.EX_MEM_rd          = ex_rd;
    bus.rs1_dout_forwarded = x17;
    bus.mem_stall          = ms;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic check_pop();
    sb_t e;
    logic [3:0] obs;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed 0 entries, required 1");
      return;
    end
    e   = sb.pop_front();
    obs = {bus.ecall_stall, bus.halt_flush, bus.halt_pending, bus.is_halted};
    checks++;
    assert (obs === e.exp)
      $display("t=%0t %s: outputs %b", $time, e.tag, obs);
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
    end
  endtask

  // Drive already applied; queue expectation, compare at negedge, advance one clock.
  task automatic step(input string tag, input logic [3:0] exp);
    sb.push_back('{tag, exp});
    @(negedge clk);
    check_pop();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input string tag);
    idle();
    sb.push_back('{tag, 4'b0000});
    #2 reset_n = 1'b0;
    #1 check_pop();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic halt_run(input string tag, input int drain_stall_at, input int drain_stall_len);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd10, 1'b0);
    step({tag, "_detect"}, 4'b0100);
    for (int i = 0; i < 3 + drain_stall_len; i++) begin
      idle();
      bus.mem_stall = (i >= drain_stall_at) && (i < drain_stall_at + drain_stall_len);
      step({tag, "_drain"}, 4'b1110);
    end
    idle();
    step({tag, "_halted"}, 4'b1101);
  endtask

  initial begin
    idle();
    step("reset_hold", 4'b0000);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step("after_reset", 4'b0000);

    // ALU producer in EX with x17==10 already visible: stall wins over halt
    drive(1'b1, 1'b1, 5'd17, 1'b0, 1'b0, 5'd0, 32'd10, 1'b0);
    step("alu_hazard", 4'b1000);
    halt_run("alu", 99, 0);
    drive(1'b1, 1'b1, 5'd17, 1'b1, 1'b1, 5'd17, 32'd10, 1'b1);
    step("halted_ignores_inputs", 4'b1101);
`ifdef ECALL_STALL_CNT_EN
    checks++;
    assert (ecall_stall_cycles === 32'd1)
      $display("t=%0t stall_cnt: %0d", $time, ecall_stall_cycles);
    else begin
      errors++;
      $error("FAIL stall_cnt: observed %0d expected 1", ecall_stall_cycles);
    end
`endif
    async_reset("reset_in_halted");
    step("run_after_reset", 4'b0000);

    // Load producer: two stall cycles (in EX, then in MEM)
    drive(1'b1, 1'b1, 5'd17, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    step("load_in_ex", 4'b1000);
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd17, 32'd0, 1'b0);
    step("load_in_mem", 4'b1000);
    halt_run("load", 99, 0);
    async_reset("reset_after_load_halt");

    // Non-hazards and non-halting ecalls
    drive(1'b1, 1'b1, 5'd16, 1'b1, 1'b1, 5'd18, 32'd93, 1'b0);
    step("other_rd_no_hazard", 4'b0000);
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd17, 32'd93, 1'b0);
    step("alu_in_mem_forwarded", 4'b0000);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd93, 1'b0);
    step("nonhalt_ecall", 4'b0000);
    idle();
    step("nonhalt_stays_run", 4'b0000);
    drive(1'b0, 1'b1, 5'd17, 1'b0, 1'b0, 5'd0, 32'd10, 1'b0);
    step("no_ecall_no_hazard", 4'b0000);

    // mem_stall in RUN: hazard still stalls, halt not detected
    drive(1'b1, 1'b1, 5'd17, 1'b0, 1'b0, 5'd0, 32'd10, 1'b1);
    step("memstall_hazard", 4'b1000);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd10, 1'b1);
    step("memstall_blocks_detect", 4'b0000);
    idle();
    step("memstall_still_run", 4'b0000);

    // Five mem_stall cycles during drain: halted at detection+9
    halt_run("drain_memstall", 1, 5);
    async_reset("reset_after_memstall");

    // Reset in DRAIN, then a fresh halt
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd10, 1'b0);
    step("mid_detect", 4'b0100);
    idle();
    step("mid_drain", 4'b1110);
    async_reset("reset_in_drain");
    step("run_after_drain_reset", 4'b0000);
    halt_run("fresh", 99, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
